// File: rtl/fft_frame_sched.sv
// rtl/fft_frame_sched.sv - round-robin whole-frame scheduler feeding one shared SDF fft core
// Optional per-source frame counters are built when FFT_SCHED_STATS_EN is defined.
module fft_frame_sched #(
  parameter int N     = 3,
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         fft_start,
  output logic [W-1:0] fft_ip,
  input  logic         fft_op_ready,
  output logic         out_valid,
  output logic         out_tag,
  output logic         out_last,
  output logic         underrun,
  output logic         orphan,
  output logic [15:0]  frames0,
  output logic [15:0]  frames1
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [N-1:0] CNT_LAST  = '1;
  localparam logic [AW:0]  DEPTH_OCC = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_n;
  logic [N-1:0]   cnt;
  logic [N-1:0]   out_cnt;
  logic           grant;
  logic           last_grant;
  logic [DEPTH-1:0] tag_mem;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    occ;
  logic [AW:0]    occ_post_pop;
  logic           fifo_empty;
  logic           pop;
  logic           push;
  logic           can_grant;
  logic           sel;
  logic           streaming;
  logic           frame_done;
  logic           stream_valid;
  logic [W-1:0]   stream_data;

  // Output side: tags leave the FIFO as the core finishes each frame.
  assign fifo_empty = (occ == '0);
  assign out_valid  = fft_op_ready & ~fifo_empty;
  assign out_tag    = ~fifo_empty & tag_mem[rd_ptr];
  assign out_last   = out_valid & (out_cnt == CNT_LAST);
  assign pop        = out_last;

  // A pop in the same cycle frees a slot for the next grant.
  assign occ_post_pop = occ - {{AW{1'b0}}, pop};
  assign can_grant    = (occ_post_pop < DEPTH_OCC) & (req0_valid | req1_valid);
  assign sel          = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

  assign streaming    = (state == STREAM);
  assign frame_done   = streaming & (cnt == CNT_LAST);
  assign req0_ready   = streaming & ~grant;
  assign req1_ready   = streaming & grant;
  assign stream_valid = grant ? req1_valid : req0_valid;
  assign stream_data  = grant ? req1_data : req0_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (can_grant) begin
          push    = 1'b1;
          state_n = STREAM;
        end
      end
      STREAM: begin
        if (cnt == CNT_LAST) begin
          if (can_grant) begin
            push = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      out_cnt    <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      fft_start  <= 1'b0;
      fft_ip     <= '0;
      underrun   <= 1'b0;
      orphan     <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= sel;
        wr_ptr          <= wr_ptr + 1'b1;
        grant           <= sel;
        last_grant      <= sel;
        cnt             <= '0;
      end else if (streaming) begin
        cnt <= cnt + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      occ <= occ_post_pop + {{AW{1'b0}}, push};

      if (out_valid) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (fft_op_ready & fifo_empty) begin
        orphan <= 1'b1;
      end

      // Underrun slots still consume a sample position so frame timing never slips.
      fft_start <= streaming & (cnt == '0);
      fft_ip    <= (streaming & stream_valid) ? stream_data : '0;
      if (streaming & ~stream_valid) begin
        underrun <= 1'b1;
      end
    end
  end

`ifdef FFT_SCHED_STATS_EN
  logic [15:0] frames0_q;
  logic [15:0] frames1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frames0_q <= '0;
      frames1_q <= '0;
    end else if (frame_done) begin
      if (~grant && frames0_q != 16'hFFFF) begin
        frames0_q <= frames0_q + 16'd1;
      end
      if (grant && frames1_q != 16'hFFFF) begin
        frames1_q <= frames1_q + 16'd1;
      end
    end
  end

  assign frames0 = frames0_q;
  assign frames1 = frames1_q;
`else
  logic unused_frame_done;
  assign unused_frame_done = frame_done;
  assign frames0 = '0;
  assign frames1 = '0;
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
// tb/tb_fft_frame_sched.sv - directed self-checking bench for fft_frame_sched
module tb_fft_frame_sched;

  localparam int N     = 3;
  localparam int W     = 32;
  localparam int DEPTH = 4;
`ifdef FFT_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready;
  logic         fft_start;
  logic [W-1:0] fft_ip;
  logic         fft_op_ready;
  logic         out_valid, out_tag, out_last;
  logic         underrun, orphan;
  logic [15:0]  frames0, frames1;

  int   checks = 0;
  int   errors = 0;
  int   d0, d1;
  logic acc0, acc1;
  logic [31:0] exp_ur [8];

  always #5 clk = ~clk;

  fft_frame_sched #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .fft_start    (fft_start),
    .fft_ip       (fft_ip),
    .fft_op_ready (fft_op_ready),
    .out_valid    (out_valid),
    .out_tag      (out_tag),
    .out_last     (out_last),
    .underrun     (underrun),
    .orphan       (orphan),
    .frames0      (frames0),
    .frames1      (frames1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sources present sequential samples and advance only on a handshake.
  task automatic tick();
    acc0 = req0_valid & req0_ready;
    acc1 = req1_valid & req1_ready;
    @(posedge clk);
    #1;
    if (acc0 === 1'b1) d0++;
    if (acc1 === 1'b1) d1++;
    req0_data = 32'(d0);
    req1_data = 32'(256 + d1);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    req0_valid   = 1'b0;
    req1_valid   = 1'b0;
    fft_op_ready = 1'b0;
    d0 = 1;
    d1 = 1;
    req0_data = 32'(d0);
    req1_data = 32'(256 + d1);
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    exp_ur = '{32'd1, 32'd2, 32'd0, 32'd0, 32'd3, 32'd4, 32'd5, 32'd6};

    do_reset();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_start", fft_start, 0);
    check("rst_ip", fft_ip, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_last", out_last, 0);
    check("rst_underrun", underrun, 0);
    check("rst_orphan", orphan, 0);
    check("rst_frames0", frames0, 0);
    check("rst_frames1", frames1, 0);

    // Single source: four back-to-back frames fill the tag FIFO.
    req0_valid = 1'b1;
    #1;
    check("a_grant_cycle_ready0", req0_ready, 0);
    tick();
    check("a_first_ready0", req0_ready, 1);
    check("a_first_ready1", req1_ready, 0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      check("a_ip", fft_ip, 32'(k));
      check("a_start", fft_start, 32'(((k - 1) % 8) == 0));
    end
    check("a_full_ready0", req0_ready, 0);
    check("a_full_ready1", req1_ready, 0);
    check("a_underrun", underrun, 0);
    check("a_frames0", frames0, 32'(STATS * 4));
    tick();
    check("a_full_hold_ready0", req0_ready, 0);
    fft_op_ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("a_out_valid", out_valid, 1);
      check("a_out_tag", out_tag, 0);
      check("a_out_last", out_last, 32'(i == 7));
      tick();
    end
    fft_op_ready = 1'b0;
    #1;
    check("a_release_ready0", req0_ready, 1);

    // Both sources: alternating grants, tags come back in order.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    tick();
    for (int k = 1; k <= 32; k++) begin
      int f, pos;
      f   = (k - 1) / 8;
      pos = (k - 1) % 8;
      tick();
      check("b_ip", fft_ip, (f % 2 == 0) ? 32'(1 + (f / 2) * 8 + pos) : 32'(257 + (f / 2) * 8 + pos));
      check("b_start", fft_start, 32'(pos == 0));
    end
    check("b_full_ready0", req0_ready, 0);
    check("b_full_ready1", req1_ready, 0);
    check("b_frames0", frames0, 32'(STATS * 2));
    check("b_frames1", frames1, 32'(STATS * 2));
    fft_op_ready = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      check("b_out_valid", out_valid, 1);
      check("b_out_tag", out_tag, 32'((i / 8) % 2));
      check("b_out_last", out_last, 32'((i % 8) == 7));
      if (i == 16) begin
        check("b_frames0_after5", frames0, 32'(STATS * 3));
        check("b_frames1_after5", frames1, 32'(STATS * 2));
      end
      tick();
    end
    fft_op_ready = 1'b0;

    // Source 0 stalls for samples 3-4: zeros fill in, frame length unchanged.
    do_reset();
    req0_valid = 1'b1;
    #1;
    tick();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      req0_valid = (cyc != 3) && (cyc != 4);
      #1;
      tick();
      check("c_ip", fft_ip, exp_ur[cyc - 1]);
    end
    check("c_underrun", underrun, 1);
    tick();
    check("c_next_start", fft_start, 1);
    check("c_next_ip", fft_ip, 7);

    // Orphan output pulse, then reset in the middle of a frame.
    do_reset();
    fft_op_ready = 1'b1;
    #1;
    check("d_orphan_out_valid", out_valid, 0);
    tick();
    fft_op_ready = 1'b0;
    #1;
    check("d_orphan", orphan, 1);
    req0_valid = 1'b1;
    #1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("d_pre_reset_ip", fft_ip, 4);
    reset = 1'b0;
    tick();
    check("d_mid_rst_ready0", req0_ready, 0);
    check("d_mid_rst_start", fft_start, 0);
    check("d_mid_rst_ip", fft_ip, 0);
    check("d_mid_rst_orphan", orphan, 0);
    check("d_mid_rst_out_valid", out_valid, 0);
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    tick();
    check("d_regrant_ready0", req0_ready, 1);
    check("d_regrant_ready1", req1_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame scheduler that shares one radix-2 SDF `fft` core between two sample sources. Grants whole 2^N-sample frames round-robin, drives the core's start pulse and sample stream, zero-fills source underruns, and tags each output frame from `op_ready` with its source ID. Sits between the capture front-ends and the `fft` instance.

## Interface
- `N`, 3: log2 frame length; frame = 2^N samples.
- `W`, 32: packed complex sample width (re/im halves).
- `DEPTH`, 4: in-flight tag FIFO depth (power of 2, ≥2).

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-low.
- `req0_valid`, `req1_valid`  in  1  source has a sample.
- `req0_data`, `req1_data`  in  W  source sample.
- `req0_ready`, `req1_ready`  out  1  sample accepted when valid&ready.
- `fft_start`  out  1  to core `start_ip`; one-cycle pulse per frame.
- `fft_ip`  out  W  to core `ip`.
- `fft_op_ready`  in  1  from core `op_ready`; high for each valid output sample.
- `out_valid`  out  1  output sample belongs to a tagged frame.
- `out_tag`  out  1  source ID (0/1) of current output frame.
- `out_last`  out  1  last output sample of frame.
- `underrun`  out  1  sticky: zero sample inserted.
- `orphan`  out  1  sticky: `fft_op_ready` with empty tag FIFO.
- `frames0`, `frames1`  out  16  completed input frames per source (see Configuration).

## Operation
- States: IDLE, STREAM.
- IDLE: if tag FIFO not full and any `reqX_valid`, grant. Both valid: grant source ≠ `last_grant`; one valid: grant it. Push grant ID into tag FIFO, load `last_grant`, go STREAM, sample count = 0.
- STREAM: `reqG_ready` = 1 for granted G only, other ready = 0. Every cycle emits one sample: `reqG_data` if `reqG_valid`, else all-zero and set `underrun`. Count increments every cycle regardless.
- Count = 2^N−1 (last sample): if next grant is possible (FIFO not full after push, a source valid) grant immediately and stay STREAM with count = 0 — no bubble; else go IDLE.
- Output side: output counter advances on each `fft_op_ready`. `out_valid` = `fft_op_ready` & FIFO non-empty; `out_tag` = FIFO head; `out_last` = `out_valid` & output count = 2^N−1; pop FIFO on `out_last`, counter wraps to 0.
- `fft_op_ready` with FIFO empty: `out_valid` = 0, set `orphan`, counter not advanced.
- Simultaneous push and pop on full FIFO: pop first, push allowed; full check uses post-pop occupancy.
- Sticky flags clear only on reset.

## Timing
- Reset (`reset`=0 at a rising edge): state IDLE, counters 0, FIFO empty, `last_grant`=1 (first tie goes to source 0), all outputs 0. Reset mid-frame aborts the frame; the core shares the same reset.
- `fft_start`, `fft_ip` registered: sample accepted in cycle t appears on `fft_ip` in t+1; `fft_start` high in the cycle carrying sample 0 of a frame.
- Back-to-back frames: `fft_start` every 2^N cycles exactly.
- Grant decision in IDLE takes one cycle; first `reqG_ready` in the following cycle.
- `reqX_ready` combinational from registered state/grant only (no valid→ready path).
- `out_valid`/`out_tag`/`out_last` combinational from `fft_op_ready` and registered FIFO head/counter.

## Configuration
- `FFT_SCHED_STATS_EN` defined: `frames0`/`frames1` increment at each completed input frame of that source, saturate at 16'hFFFF, reset to 0.
- Undefined: counters not built, `frames0`/`frames1` tied to 0; all other behaviour identical.

## Test plan
- N=3, only req0 valid, samples 1..8 -> one `fft_start` pulse with `fft_ip`=1 same cycle, 8 consecutive samples, tag 0 pushed; after 8 `fft_op_ready` cycles `out_tag`=0, `out_last` on 8th.
- Both sources valid continuously for 4 frames -> grants 0,1,0,1; `fft_start` spacing exactly 8 cycles; output tags 0,1,0,1.
- req0 drops valid for samples 3–4 -> `fft_ip`=0 on those cycles, `underrun`=1, frame still 8 samples, next frame starts on schedule.
- DEPTH=4, `fft_op_ready` held low -> 4 frames issued, then all `reqX_ready`=0, IDLE; first `out_last` releases one grant next cycle.
- `fft_op_ready` pulsed with no frame issued -> `out_valid`=0, `orphan`=1; `reset`=0 mid-frame at sample 5 -> all outputs 0, FIFO empty, next frame grants source 0.
- With `FFT_SCHED_STATS_EN`: 3 req0 frames, 2 req1 frames -> `frames0`=3, `frames1`=2; without it both read 0.
